// File: rtl/proc_err_monitor_if.sv
// Retire-stream and status bundle between the processor bench and its run monitor.
// Latency: none, plain wires.
// Backpressure: none; the retire stream is observed, never stalled.
// Ports (signals):
//   retire, retire_pc, halt               retire stream driven by the master
//   err, err_code, done, cycle_cnt,       run status driven by the slave (monitor)
//   instr_cnt
interface proc_err_monitor_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             retire;
  logic [PC_W-1:0]  retire_pc;
  logic             halt;
  logic             err;
  logic [1:0]       err_code;
  logic             done;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output retire, retire_pc, halt,
    input  err, err_code, done, cycle_cnt, instr_cnt
  );

  modport slave (
    input  retire, retire_pc, halt,
    output err, err_code, done, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/proc_err_monitor.sv
// Run monitor: flags misaligned retire PC, retire starvation and cycle-budget overrun; flags halt completion.
// Latency: err/done/counters are registered, visible the cycle after the causing input.
// Backpressure: none; purely observes the retire stream.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high; returns to HOLD from any state
//   mon        slave side of proc_err_monitor_if (retire stream in, err/done/counters out)
module proc_err_monitor #(
  parameter int TIMEOUT    = 16,
  parameter int MAX_CYCLES = 1000,
  parameter int PC_W       = 32,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  proc_err_monitor_if.slave  mon
);

  localparam int IDLE_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic misaligned;
  logic unused_pc_hi;

  // Only the low two PC bits matter for alignment.
  assign unused_pc_hi = ^mon.retire_pc[PC_W-1:2];
  assign misaligned   = mon.retire && (mon.retire_pc[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    done_d      = done_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    idle_d      = idle_q;

    case (state_q)
      S_HOLD: state_d = S_RUN;

      S_RUN: begin
        // Counting happens on every RUN cycle, including the one that ends the run.
        if (cycle_cnt_q != {CNT_W{1'b1}}) cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (mon.retire) begin
          if (instr_cnt_q != {CNT_W{1'b1}}) instr_cnt_d = instr_cnt_q + 1'b1;
          idle_d = '0;
        end else begin
          // Cannot overflow: the timeout fault fires before idle reaches TIMEOUT.
          idle_d = idle_q + 1'b1;
        end

        // Priority chain: misalignment beats halt, halt beats both timers,
        // timeout beats budget.
        if (misaligned) begin
          state_d    = S_ERROR;
          err_d      = 1'b1;
          err_code_d = 2'b01;
        end else if (mon.retire && mon.halt) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else if (!mon.retire && (idle_q == IDLE_W'(TIMEOUT - 1))) begin
          state_d    = S_ERROR;
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d    = S_ERROR;
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end
      end

      // HALTED and ERROR are terminal: everything holds until rst.
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      done_q      <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      idle_q      <= idle_d;
    end
  end

  assign mon.err       = err_q;
  assign mon.err_code  = err_code_q;
  assign mon.done      = done_q;
  assign mon.cycle_cnt = cycle_cnt_q;
  assign mon.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_proc_err_monitor.sv
// Bench for proc_err_monitor: three instances share one retire stream.
//   a: TIMEOUT=16, MAX_CYCLES=1000   b: TIMEOUT=16, MAX_CYCLES=8   c: TIMEOUT=8, MAX_CYCLES=8
// Stimulus queues hand-computed snapshots; a negedge monitor pops and compares them.
module tb_proc_err_monitor;

  typedef struct packed {
    logic        err;
    logic [1:0]  code;
    logic        done;
    logic [15:0] cyc;
    logic [15:0] instr;
  } snap_t;

  typedef struct {
    int    due;
    int    dut;
    string name;
    snap_t exp;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire;
  logic [31:0] pc;
  logic        halt;
  int          tick = 0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  entry_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  proc_err_monitor_if #(.PC_W(32), .CNT_W(16)) if_a ();
  proc_err_monitor_if #(.PC_W(32), .CNT_W(16)) if_b ();
  proc_err_monitor_if #(.PC_W(32), .CNT_W(16)) if_c ();

  assign if_a.retire = retire;  assign if_a.retire_pc = pc;  assign if_a.halt = halt;
  assign if_b.retire = retire;  assign if_b.retire_pc = pc;  assign if_b.halt = halt;
  assign if_c.retire = retire;  assign if_c.retire_pc = pc;  assign if_c.halt = halt;

  proc_err_monitor #(.TIMEOUT(16), .MAX_CYCLES(1000), .PC_W(32), .CNT_W(16))
    dut_a (.clk(clk), .rst(rst), .mon(if_a));
  proc_err_monitor #(.TIMEOUT(16), .MAX_CYCLES(8), .PC_W(32), .CNT_W(16))
    dut_b (.clk(clk), .rst(rst), .mon(if_b));
  proc_err_monitor #(.TIMEOUT(8), .MAX_CYCLES(8), .PC_W(32), .CNT_W(16))
    dut_c (.clk(clk), .rst(rst), .mon(if_c));

  function automatic snap_t get_snap(input int d);
    snap_t s;
    case (d)
      0:       s = {if_a.err, if_a.err_code, if_a.done, if_a.cycle_cnt, if_a.instr_cnt};
      1:       s = {if_b.err, if_b.err_code, if_b.done, if_b.cycle_cnt, if_b.instr_cnt};
      default: s = {if_c.err, if_c.err_code, if_c.done, if_c.cycle_cnt, if_c.instr_cnt};
    endcase
    return s;
  endfunction

  // Expected snapshot for the state that follows the most recent clock edge.
  task automatic expect_now(input int d, input string nm, input logic e, input logic [1:0] c,
                            input logic dn, input int cy, input int in);
    entry_t ent;
    ent.due       = tick;
    ent.dut       = d;
    ent.name      = nm;
    ent.exp.err   = e;
    ent.exp.code  = c;
    ent.exp.done  = dn;
    ent.exp.cyc   = 16'(cy);
    ent.exp.instr = 16'(in);
    sb.push_back(ent);
  endtask

  // Monitor: compares every queued expectation at the negedge it falls due.
  initial begin
    entry_t ent;
    snap_t  act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= tick) begin
        ent = sb.pop_front();
        act = get_snap(ent.dut);
        n_checks++;
        if (ent.due != tick) begin
          n_fail++;
          $display("FAIL %s dut%0d: expectation not compared on its cycle (due %0d, now %0d)",
                   ent.name, ent.dut, ent.due, tick);
        end else if (act === ent.exp) begin
          n_pass++;
        end else begin
          n_fail++;
          $display("FAIL %s dut%0d: got err=%0b code=%b done=%0b cyc=%0d instr=%0d, want err=%0b code=%b done=%0b cyc=%0d instr=%0d",
                   ent.name, ent.dut, act.err, act.code, act.done, act.cyc, act.instr,
                   ent.exp.err, ent.exp.code, ent.exp.done, ent.exp.cyc, ent.exp.instr);
        end
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] p, input logic h);
    retire = r;
    pc     = p;
    halt   = h;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) expect_now(d, "reset", 1'b0, 2'b00, 1'b0, 0, 0);
  endtask

  initial begin
    rst    = 1'b1;
    retire = 1'b0;
    pc     = 32'h0;
    halt   = 1'b0;

    // Normal run ending in halt.
    do_reset();
    idle(1);                                         // HOLD
    expect_now(0, "hold_no_count", 1'b0, 2'b00, 1'b0, 0, 0);
    idle(1);
    expect_now(0, "run_idle", 1'b0, 2'b00, 1'b0, 1, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), 1'b0);
    step(1'b1, 32'd20, 1'b1);
    expect_now(0, "halt_done", 1'b0, 2'b00, 1'b1, 7, 6);
    expect_now(1, "halt_done", 1'b0, 2'b00, 1'b1, 7, 6);
    expect_now(2, "halt_done", 1'b0, 2'b00, 1'b1, 7, 6);
    idle(2);
    expect_now(0, "halted_frozen", 1'b0, 2'b00, 1'b1, 7, 6);

    // Retire starvation; b hits the budget first, c hits timeout and budget together.
    do_reset();
    idle(1);                                         // HOLD
    idle(8);
    expect_now(1, "budget_idle", 1'b1, 2'b11, 1'b0, 8, 0);
    expect_now(2, "timeout_and_budget", 1'b1, 2'b10, 1'b0, 8, 0);
    expect_now(0, "idle_8", 1'b0, 2'b00, 1'b0, 8, 0);
    idle(7);
    expect_now(0, "idle_15", 1'b0, 2'b00, 1'b0, 15, 0);
    idle(1);
    expect_now(0, "timeout", 1'b1, 2'b10, 1'b0, 16, 0);
    idle(3);
    expect_now(0, "error_frozen", 1'b1, 2'b10, 1'b0, 16, 0);
    expect_now(1, "error_frozen", 1'b1, 2'b11, 1'b0, 8, 0);

    // Misaligned retire PC.
    do_reset();
    idle(1);
    step(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0006, 1'b0);
    expect_now(0, "misaligned", 1'b1, 2'b01, 1'b0, 2, 2);
    do_reset();
    idle(1);
    step(1'b1, 32'h0000_0002, 1'b1);
    expect_now(0, "misaligned_halt", 1'b1, 2'b01, 1'b0, 1, 1);

    // Cycle budget with retire every cycle, then halt on the final budget cycle.
    do_reset();
    idle(1);
    for (int i = 0; i < 7; i++) step(1'b1, 32'(i * 4), 1'b0);
    expect_now(1, "budget_minus1", 1'b0, 2'b00, 1'b0, 7, 7);
    step(1'b1, 32'd28, 1'b0);
    expect_now(1, "budget", 1'b1, 2'b11, 1'b0, 8, 8);
    expect_now(2, "budget", 1'b1, 2'b11, 1'b0, 8, 8);
    do_reset();
    idle(1);
    for (int i = 0; i < 7; i++) step(1'b1, 32'(i * 4), 1'b0);
    step(1'b1, 32'd28, 1'b1);
    expect_now(1, "halt_on_budget", 1'b0, 2'b00, 1'b1, 8, 8);

    // Retire during HOLD is ignored; reset mid-run.
    do_reset();
    step(1'b1, 32'h0, 1'b0);                         // HOLD
    expect_now(0, "hold_retire", 1'b0, 2'b00, 1'b0, 0, 0);
    for (int i = 1; i <= 3; i++) step(1'b1, 32'(i * 4), 1'b0);
    expect_now(0, "pre_midrst", 1'b0, 2'b00, 1'b0, 3, 3);
    rst = 1'b1;
    step(1'b1, 32'd16, 1'b0);
    rst = 1'b0;
    expect_now(0, "midrun_reset", 1'b0, 2'b00, 1'b0, 0, 0);
    step(1'b1, 32'h0, 1'b0);                         // HOLD
    expect_now(0, "hold_after_rst", 1'b0, 2'b00, 1'b0, 0, 0);
    step(1'b1, 32'h4, 1'b0);
    expect_now(0, "run_after_rst", 1'b0, 2'b00, 1'b0, 1, 1);

    // halt without retire is ignored.
    do_reset();
    idle(1);
    step(1'b1, 32'h0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b1);
    expect_now(0, "halt_no_retire", 1'b0, 2'b00, 1'b0, 4, 1);

    idle(2);
    n_checks++;
    if (sb.size() == 0) begin
      n_pass++;
    end else begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
